// File: rtl/rv_iopmp_err_capture.sv
// rv_iopmp_err_capture
// Captures the first IOPMP violation reported by any matching-logic instance
// and holds it until software clears it. Instances are served round-robin.
// Optional feature macro: RV_IOPMP_ERR_SUPP_CNT_EN adds supp_cnt_o, a
// saturating count of reports dropped while a record is held.
module rv_iopmp_err_capture #(
    parameter int unsigned NUMBER_TL_INSTANCES = 1,
    parameter int unsigned ADDR_WIDTH          = 64,
    parameter int unsigned SID_WIDTH           = 1,
    parameter int unsigned CNT_WIDTH           = 16
) (
    input  logic                                            clk_i,
    input  logic                                            rst_ni,
    input  logic [NUMBER_TL_INSTANCES-1:0]                  err_valid_i,
    input  logic [NUMBER_TL_INSTANCES-1:0][ADDR_WIDTH-1:0]  err_addr_i,
    input  logic [NUMBER_TL_INSTANCES-1:0][SID_WIDTH-1:0]   err_sid_i,
    input  logic [NUMBER_TL_INSTANCES-1:0][1:0]             err_ttype_i,
    input  logic [NUMBER_TL_INSTANCES-1:0][2:0]             err_etype_i,
    output logic [NUMBER_TL_INSTANCES-1:0]                  err_ack_o,
    input  logic                                            clear_i,
    input  logic                                            intr_en_i,
    output logic                                            rec_valid_o,
    output logic [ADDR_WIDTH-1:0]                           rec_addr_o,
    output logic [SID_WIDTH-1:0]                            rec_sid_o,
    output logic [1:0]                                      rec_ttype_o,
    output logic [2:0]                                      rec_etype_o,
    output logic                                            wsi_wire_o
`ifdef RV_IOPMP_ERR_SUPP_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]                            supp_cnt_o
`endif
);

    localparam int unsigned N    = NUMBER_TL_INSTANCES;
    localparam int unsigned RR_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_e;

    state_e                  state_reg, state_next;
    logic [RR_W-1:0]         rr_q, rr_next;
    logic [N-1:0]            eligible;
    logic [2*N-1:0]          rotated;
    logic                    found;
    logic                    accept;
    logic [RR_W-1:0]         winner;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [SID_WIDTH-1:0]    sel_sid;
    logic [1:0]              sel_ttype;
    logic [2:0]              sel_etype;
    logic [ADDR_WIDTH-1:0]   rec_addr_reg;
    logic [SID_WIDTH-1:0]    rec_sid_reg;
    logic [1:0]              rec_ttype_reg;
    logic [2:0]              rec_etype_reg;

    // A report with the reserved transaction type 0 is never a candidate.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_elig
            assign eligible[gi] = err_valid_i[gi] && (err_ttype_i[gi] != 2'd0);
        end
    endgenerate

    assign rotated = {eligible, eligible} >> rr_q;

    // Round-robin search: first eligible instance at or after rr_q.
    always_comb begin
        int unsigned widx;
        found  = 1'b0;
        winner = '0;
        widx   = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && rotated[k]) begin
                found = 1'b1;
                widx  = int'(rr_q) + k;
                if (widx >= N) widx = widx - N;
                winner = RR_W'(widx);
            end
        end
    end

    // Field mux for the winning instance.
    always_comb begin
        sel_addr  = '0;
        sel_sid   = '0;
        sel_ttype = '0;
        sel_etype = '0;
        for (int j = 0; j < N; j++) begin
            if (winner == RR_W'(j)) begin
                sel_addr  = err_addr_i[j];
                sel_sid   = err_sid_i[j];
                sel_ttype = err_ttype_i[j];
                sel_etype = err_etype_i[j];
            end
        end
    end

    // A clear in HELD frees the slot in the same cycle, so a coincident
    // report is taken instead of being dropped.
    assign accept = found && ((state_reg == IDLE) || clear_i);

    // Next-state, pointer advance and acknowledge generation.
    always_comb begin
        state_next = state_reg;
        rr_next    = rr_q;
        err_ack_o  = '0;
        case (state_reg)
            IDLE: if (accept) state_next = HELD;
            HELD: if (!accept && clear_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (accept) begin
            rr_next = (winner == RR_W'(N - 1)) ? '0 : winner + RR_W'(1);
        end
        for (int j = 0; j < N; j++) begin
            err_ack_o[j] = accept && rst_ni && (winner == RR_W'(j));
        end
    end

    // State, pointer and record registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            rr_q          <= '0;
            rec_addr_reg  <= '0;
            rec_sid_reg   <= '0;
            rec_ttype_reg <= '0;
            rec_etype_reg <= '0;
        end else begin
            state_reg <= state_next;
            rr_q      <= rr_next;
            if (accept) begin
                rec_addr_reg  <= sel_addr;
                rec_sid_reg   <= sel_sid;
                rec_ttype_reg <= sel_ttype;
                rec_etype_reg <= sel_etype;
            end
        end
    end

    assign rec_valid_o = (state_reg == HELD);
    assign rec_addr_o  = rec_addr_reg;
    assign rec_sid_o   = rec_sid_reg;
    assign rec_ttype_o = rec_ttype_reg;
    assign rec_etype_o = rec_etype_reg;
    assign wsi_wire_o  = rec_valid_o && intr_en_i;

`ifdef RV_IOPMP_ERR_SUPP_CNT_EN
    logic [CNT_WIDTH-1:0] supp_cnt_reg, supp_cnt_next;

    // Count every eligible report dropped while held; clear wins.
    always_comb begin
        supp_cnt_next = supp_cnt_reg;
        if (state_reg == HELD) begin
            if (clear_i) begin
                supp_cnt_next = '0;
            end else begin
                for (int j = 0; j < N; j++) begin
                    if (eligible[j] && (supp_cnt_next != '1)) begin
                        supp_cnt_next = supp_cnt_next + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    // Suppressed-report counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) supp_cnt_reg <= '0;
        else         supp_cnt_reg <= supp_cnt_next;
    end

    assign supp_cnt_o = supp_cnt_reg;
`endif

endmodule

// File: tb/tb_rv_iopmp_err_capture.sv
// Testbench for rv_iopmp_err_capture: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
module tb_rv_iopmp_err_capture;

    localparam int N   = 2;
    localparam int AW  = 64;
    localparam int SW  = 4;
    localparam int CW  = 3;
    localparam int SUPP_MAX = (1 << CW) - 1;

    logic                   clk;
    logic                   rst_ni;
    logic [N-1:0]           err_valid;
    logic [N-1:0][AW-1:0]   err_addr;
    logic [N-1:0][SW-1:0]   err_sid;
    logic [N-1:0][1:0]      err_ttype;
    logic [N-1:0][2:0]      err_etype;
    logic [N-1:0]           err_ack;
    logic                   clear;
    logic                   intr_en;
    logic                   rec_valid;
    logic [AW-1:0]          rec_addr;
    logic [SW-1:0]          rec_sid;
    logic [1:0]             rec_ttype;
    logic [2:0]             rec_etype;
    logic                   wsi_wire;
`ifdef RV_IOPMP_ERR_SUPP_CNT_EN
    logic [CW-1:0]          supp_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int txn      = 0;

    // Reference model: what the unit is holding, as plain values.
    bit             exp_held;
    logic [AW-1:0]  exp_addr;
    logic [SW-1:0]  exp_sid;
    logic [1:0]     exp_ttype;
    logic [2:0]     exp_etype;
    int             exp_rr;
    int             exp_supp;

    rv_iopmp_err_capture #(
        .NUMBER_TL_INSTANCES (N),
        .ADDR_WIDTH          (AW),
        .SID_WIDTH           (SW),
        .CNT_WIDTH           (CW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .err_valid_i (err_valid),
        .err_addr_i  (err_addr),
        .err_sid_i   (err_sid),
        .err_ttype_i (err_ttype),
        .err_etype_i (err_etype),
        .err_ack_o   (err_ack),
        .clear_i     (clear),
        .intr_en_i   (intr_en),
        .rec_valid_o (rec_valid),
        .rec_addr_o  (rec_addr),
        .rec_sid_o   (rec_sid),
        .rec_ttype_o (rec_ttype),
        .rec_etype_o (rec_etype),
        .wsi_wire_o  (wsi_wire)
`ifdef RV_IOPMP_ERR_SUPP_CNT_EN
        ,
        .supp_cnt_o  (supp_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic bit is_eligible(input int i);
        return err_valid[i] && (err_ttype[i] != 2'd0);
    endfunction

    // Which instance would be accepted this cycle, or -1.
    function automatic int model_pick();
        if (exp_held && !clear) return -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (exp_rr + k) % N;
            if (is_eligible(idx)) return idx;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        exp_held  = 1'b0;
        exp_addr  = '0;
        exp_sid   = '0;
        exp_ttype = '0;
        exp_etype = '0;
        exp_rr    = 0;
        exp_supp  = 0;
    endfunction

    // Apply one clock edge to the model, w being the accepted instance.
    function automatic void model_update(input int w);
        bit was_held;
        was_held = exp_held;
        if (was_held && clear) exp_supp = 0;
        if (w >= 0) begin
            exp_held  = 1'b1;
            exp_addr  = err_addr[w];
            exp_sid   = err_sid[w];
            exp_ttype = err_ttype[w];
            exp_etype = err_etype[w];
            exp_rr    = (w + 1) % N;
        end else if (was_held) begin
            if (clear) begin
                exp_held = 1'b0;
            end else begin
                for (int i = 0; i < N; i++)
                    if (is_eligible(i) && exp_supp < SUPP_MAX) exp_supp++;
            end
        end
    endfunction

    task automatic check_state();
        check_value("rec_valid", rec_valid, exp_held);
        check_value("wsi_wire", wsi_wire, exp_held & intr_en);
        if (exp_held) begin
            check_value("rec_addr", rec_addr, exp_addr);
            check_value("rec_sid", rec_sid, exp_sid);
            check_value("rec_ttype", rec_ttype, exp_ttype);
            check_value("rec_etype", rec_etype, exp_etype);
        end
`ifdef RV_IOPMP_ERR_SUPP_CNT_EN
        check_value("supp_cnt", supp_cnt, exp_supp);
`endif
    endtask

    // One transaction: drive after the falling edge, check, clock, update.
    task automatic do_cycle(input logic [N-1:0] v, input logic clr);
        int w;
        logic [N-1:0] exp_ack;
        err_valid = v;
        clear     = clr;
        #1;
        w = model_pick();
        exp_ack = (w >= 0) ? (N'(1) << w) : '0;
        check_value("ack", err_ack, exp_ack);
        check_state();
        $display("txn %0d: valid=%b clear=%b ack=%b held=%b addr=0x%0h",
                 txn, v, clr, err_ack, rec_valid, rec_addr);
        txn++;
        @(posedge clk);
        model_update(w);
        @(negedge clk);
        err_valid = '0;
        clear     = 1'b0;
    endtask

    task automatic set_fields(input int i, input logic [AW-1:0] a,
                              input logic [1:0] tt, input logic [2:0] et,
                              input logic [SW-1:0] s);
        err_addr[i]  = a;
        err_ttype[i] = tt;
        err_etype[i] = et;
        err_sid[i]   = s;
    endtask

    initial begin
        rst_ni    = 1'b0;
        err_valid = '0;
        err_addr  = '0;
        err_sid   = '0;
        err_ttype = '0;
        err_etype = '0;
        clear     = 1'b0;
        intr_en   = 1'b0;
        model_reset();

        // Reset state; acknowledge must stay low even with reports present.
        set_fields(0, 64'h1000, 2'd1, 3'd1, 4'h1);
        set_fields(1, 64'h2000, 2'd2, 3'd2, 4'h2);
        err_valid = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        check_value("reset_ack", err_ack, 2'b00);
        check_value("reset_rec_valid", rec_valid, 1'b0);
        check_value("reset_wsi", wsi_wire, 1'b0);
        check_value("reset_rec_addr", rec_addr, 64'h0);
        check_value("reset_rec_sid", rec_sid, 4'h0);
        check_value("reset_rec_ttype", rec_ttype, 2'd0);
        check_value("reset_rec_etype", rec_etype, 3'd0);
        err_valid = '0;
        @(negedge clk);
        rst_ni = 1'b1;

        // Both report: instance 0 wins first, then instance 1 after a clear.
        do_cycle(2'b11, 1'b0);
        do_cycle(2'b00, 1'b1);
        do_cycle(2'b11, 1'b0);

        // Held with interrupts on: three drops counted, record untouched.
        intr_en = 1'b1;
        set_fields(0, 64'h3000, 2'd3, 3'd4, 4'h3);
        do_cycle(2'b01, 1'b0);
        do_cycle(2'b01, 1'b0);
        do_cycle(2'b01, 1'b0);

        // Clear together with a new report: the new report replaces the record.
        set_fields(0, 64'hBEEF, 2'd2, 3'd5, 4'h7);
        do_cycle(2'b01, 1'b1);
        do_cycle(2'b00, 1'b0);

        // Asynchronous reset while held with the interrupt asserted.
        err_valid = 2'b11;
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_value("areset_wsi", wsi_wire, 1'b0);
        check_value("areset_rec_valid", rec_valid, 1'b0);
        check_value("areset_ack", err_ack, 2'b00);
        check_value("areset_rec_addr", rec_addr, 64'h0);
        @(negedge clk);
        err_valid = '0;
        rst_ni    = 1'b1;

        // Reserved transaction type in IDLE: ignored.
        set_fields(0, 64'h4000, 2'd0, 3'd1, 4'h4);
        do_cycle(2'b01, 1'b0);
        do_cycle(2'b00, 1'b0);

        // Clear in IDLE has no effect.
        do_cycle(2'b00, 1'b1);

        // Random traffic.
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                set_fields(i, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
                           3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            end
            if ($urandom_range(0, 15) == 0) intr_en = ~intr_en;
            do_cycle(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
